// File: rtl/arb_pkg.sv
// Shared types for the data-RAM port arbiter: FSM state encodings, read-owner
// codes and the round-robin pick between the two read requesters.
package arb_pkg;

    localparam int ADR_W  = 32;
    localparam int DATA_W = 128;
    localparam int MASK_W = 16;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_RD_MON = 2'd1,
        ARB_RD_CPU = 2'd2
    } arb_state_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_MON = 1'b1
    } owner_e;

    // With both requesters present the one that did not win last time goes first.
    function automatic owner_e rr_pick(input logic mon_cand, input logic cpu_cand,
                                       input owner_e last_grant);
        if (mon_cand && cpu_cand) begin
            return (last_grant == OWN_CPU) ? OWN_MON : OWN_CPU;
        end
        return mon_cand ? OWN_MON : OWN_CPU;
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// Monitor, CPU and memory-side signals of the data-RAM port arbiter.
// slave = arbiter view, master = the surrounding monitor/CPU/memory.
interface dram_port_arbiter_if;
    import arb_pkg::*;

    logic              mon_active;
    logic              mon_read_start;
    logic [ADR_W-1:0]  mon_radr;
    logic [DATA_W-1:0] mon_rdata;
    logic              mon_read_valid;
    logic              mon_wen;
    logic [ADR_W-1:0]  mon_wadr;
    logic [DATA_W-1:0] mon_wdata;
    logic [MASK_W-1:0] mon_mask;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADR_W-1:0]  cpu_adr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [MASK_W-1:0] cpu_mask;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              mem_read_start;
    logic [ADR_W-1:0]  mem_radr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_read_valid;
    logic              mem_wen;
    logic [ADR_W-1:0]  mem_wadr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_mask;

    logic              rd_timeout;

    modport slave (
        input  mon_active, mon_read_start, mon_radr, mon_wen, mon_wadr, mon_wdata, mon_mask,
        output mon_rdata, mon_read_valid,
        input  cpu_req, cpu_we, cpu_adr, cpu_wdata, cpu_mask,
        output cpu_ack, cpu_rdata, cpu_rvalid,
        output mem_read_start, mem_radr, mem_wen, mem_wadr, mem_wdata, mem_mask,
        input  mem_rdata, mem_read_valid,
        output rd_timeout
    );

    modport master (
        output mon_active, mon_read_start, mon_radr, mon_wen, mon_wadr, mon_wdata, mon_mask,
        input  mon_rdata, mon_read_valid,
        output cpu_req, cpu_we, cpu_adr, cpu_wdata, cpu_mask,
        input  cpu_ack, cpu_rdata, cpu_rvalid,
        input  mem_read_start, mem_radr, mem_wen, mem_wadr, mem_wdata, mem_mask,
        output mem_rdata, mem_read_valid,
        input  rd_timeout
    );

endinterface

// File: rtl/arb_rd_watchdog.sv
// Read-timeout counter: cleared by the issue pulse, counts while a read is
// outstanding, and flags expiry RD_TIMEOUT cycles after issue unless data arrives.
module arb_rd_watchdog #(
    parameter int RD_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic active,
    input  logic valid,
    output logic expire
);

    logic [TO_W-1:0] cnt_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (active) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The issue cycle still holds the previous read's count, so it never expires.
    assign expire = active && !start && !valid && (cnt_q == TO_W'(RD_TIMEOUT - 1));

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares the 128-bit data-RAM port between the CPU and the UART monitor.
// Optional ARB_MON_HOLD_EN: the CPU is locked out entirely while mon_active=1.
module dram_port_arbiter
    import arb_pkg::*;
#(
    parameter int RD_TIMEOUT = 64,
    parameter int TO_W       = 7
) (
    input logic                 clk,
    input logic                 rst_n,
    dram_port_arbiter_if.slave  bus
);

    arb_state_e        state_q, state_d;
    owner_e            last_grant_q;
    logic              mon_pend_q;
    logic [ADR_W-1:0]  mon_adr_q;
    logic              mem_read_start_q;
    logic [ADR_W-1:0]  mem_radr_q;

    logic hold;
    logic mon_cand, cpu_cand;
    logic grant_mon, grant_cpu;
    logic cpu_wr_ok;
    logic expire;

`ifdef ARB_MON_HOLD_EN
    assign hold = bus.mon_active;
`else
    logic unused_mon_active;
    assign hold              = 1'b0;
    assign unused_mon_active = bus.mon_active;
`endif

    // A start pulse seen in ARB_IDLE is a candidate at once, saving a cycle.
    assign mon_cand  = mon_pend_q || bus.mon_read_start;
    assign cpu_cand  = bus.cpu_req && !bus.cpu_we && !hold;
    assign cpu_wr_ok = bus.cpu_req && bus.cpu_we && !bus.mon_wen && !hold;

    arb_rd_watchdog #(
        .RD_TIMEOUT (RD_TIMEOUT),
        .TO_W       (TO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mem_read_start_q),
        .active (state_q != ARB_IDLE),
        .valid  (bus.mem_read_valid),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_d   = state_q;
        grant_mon = 1'b0;
        grant_cpu = 1'b0;
        unique case (state_q)
            ARB_IDLE: begin
                if (mon_cand || cpu_cand) begin
                    if (rr_pick(mon_cand, cpu_cand, last_grant_q) == OWN_MON) begin
                        grant_mon = 1'b1;
                        state_d   = ARB_RD_MON;
                    end else begin
                        grant_cpu = 1'b1;
                        state_d   = ARB_RD_CPU;
                    end
                end
            end
            ARB_RD_MON, ARB_RD_CPU: begin
                if (bus.mem_read_valid || expire) begin
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // NOTE: the pending address and issue address are reset too, so the memory
    // never sees an X address even though only the strobe qualifies it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q     <= OWN_CPU;
            mon_pend_q       <= 1'b0;
            mon_adr_q        <= '0;
            mem_read_start_q <= 1'b0;
            mem_radr_q       <= '0;
        end else begin
            mem_read_start_q <= grant_mon || grant_cpu;
            if (grant_mon) begin
                mem_radr_q   <= mon_pend_q ? mon_adr_q : bus.mon_radr;
                last_grant_q <= OWN_MON;
            end else if (grant_cpu) begin
                mem_radr_q   <= bus.cpu_adr;
                last_grant_q <= OWN_CPU;
            end

            // A start coincident with granting the old pending read stays pending.
            if (grant_mon) begin
                mon_pend_q <= mon_pend_q && bus.mon_read_start;
            end else if (bus.mon_read_start) begin
                mon_pend_q <= 1'b1;
            end
            if (bus.mon_read_start) begin
                mon_adr_q <= bus.mon_radr;
            end
        end
    end

    assign bus.mem_read_start = mem_read_start_q;
    assign bus.mem_radr       = mem_radr_q;
    assign bus.rd_timeout     = expire;

    // Read return routing: data 0 on abort; a valid in ARB_IDLE reaches no one.
    always_comb begin
        bus.mon_read_valid = 1'b0;
        bus.mon_rdata      = '0;
        bus.cpu_rvalid     = 1'b0;
        bus.cpu_rdata      = '0;
        if (state_q == ARB_RD_MON) begin
            bus.mon_read_valid = bus.mem_read_valid || expire;
            bus.mon_rdata      = bus.mem_read_valid ? bus.mem_rdata : '0;
        end else if (state_q == ARB_RD_CPU) begin
            bus.cpu_rvalid = bus.mem_read_valid || expire;
            bus.cpu_rdata  = bus.mem_read_valid ? bus.mem_rdata : '0;
        end
    end

    // Write path is pass-through; reset forces the strobe and buses low.
    always_comb begin
        bus.mem_wen   = 1'b0;
        bus.mem_wadr  = '0;
        bus.mem_wdata = '0;
        bus.mem_mask  = '0;
        bus.cpu_ack   = 1'b0;
        if (rst_n) begin
            if (bus.mon_wen) begin
                bus.mem_wen   = 1'b1;
                bus.mem_wadr  = bus.mon_wadr;
                bus.mem_wdata = bus.mon_wdata;
                bus.mem_mask  = bus.mon_mask;
            end else if (cpu_wr_ok) begin
                bus.mem_wen   = 1'b1;
                bus.mem_wadr  = bus.cpu_adr;
                bus.mem_wdata = bus.cpu_wdata;
                bus.mem_mask  = bus.cpu_mask;
            end
            bus.cpu_ack = cpu_wr_ok || grant_cpu;
        end
    end

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Directed bench for dram_port_arbiter with a 4-cycle read timeout; read issues
// and read returns are checked against scoreboard queues filled by the stimulus.
module tb_dram_port_arbiter;
    import arb_pkg::*;

    typedef struct {
        owner_e            own;
        logic [DATA_W-1:0] data;
    } ret_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    ret_t             ret_q[$];
    logic [ADR_W-1:0] iss_q[$];

    dram_port_arbiter_if bus();

    dram_port_arbiter #(
        .RD_TIMEOUT (4),
        .TO_W       (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic expect_issue(input string tag);
        logic [ADR_W-1:0] e;
        e = 'x;
        if (iss_q.size() != 0) e = iss_q.pop_front();
        chk({tag, " mem_read_start"}, bus.mem_read_start, 1);
        chk({tag, " mem_radr"}, bus.mem_radr, e);
    endtask

    task automatic expect_ret(input string tag);
        ret_t r;
        r.own  = OWN_CPU;
        r.data = 'x;
        if (ret_q.size() != 0) r = ret_q.pop_front();
        chk({tag, " mon_read_valid"}, bus.mon_read_valid, r.own == OWN_MON);
        chk({tag, " cpu_rvalid"}, bus.cpu_rvalid, r.own == OWN_CPU);
        chk({tag, " rdata"}, (r.own == OWN_MON) ? bus.mon_rdata : bus.cpu_rdata, r.data);
    endtask

    task automatic expect_quiet(input string tag);
        chk({tag, " mem_read_start"}, bus.mem_read_start, 0);
        chk({tag, " mon_read_valid"}, bus.mon_read_valid, 0);
        chk({tag, " cpu_rvalid"}, bus.cpu_rvalid, 0);
        chk({tag, " rd_timeout"}, bus.rd_timeout, 0);
    endtask

    initial begin
        logic [DATA_W-1:0] pat;
        n_pass  = 0;
        n_total = 0;
        rst_n   = 1'b0;
        bus.mon_active = 0; bus.mon_read_start = 0; bus.mon_radr = 0;
        bus.mon_wen = 0; bus.mon_wadr = 0; bus.mon_wdata = 0; bus.mon_mask = 0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_adr = 0; bus.cpu_wdata = 0; bus.cpu_mask = 0;
        bus.mem_rdata = 0; bus.mem_read_valid = 0;

        // Reset state
        repeat (2) tick();
        settle();
        chk("rst mem_read_start", bus.mem_read_start, 0);
        chk("rst mem_radr", bus.mem_radr, 0);
        chk("rst mem_wen", bus.mem_wen, 0);
        chk("rst mem_wadr", bus.mem_wadr, 0);
        chk("rst mem_wdata", bus.mem_wdata, 0);
        chk("rst mem_mask", bus.mem_mask, 0);
        chk("rst cpu_ack", bus.cpu_ack, 0);
        chk("rst cpu_rdata", bus.cpu_rdata, 0);
        chk("rst mon_rdata", bus.mon_rdata, 0);
        expect_quiet("rst");
        tick(); rst_n = 1'b1;

        // Basic monitor read, data after 3 cycles
        tick(); bus.mon_read_start = 1; bus.mon_radr = 32'h100; iss_q.push_back(32'h100); settle();
        chk("basic early", bus.mem_read_start, 0);
        tick(); bus.mon_read_start = 0; settle();
        expect_issue("basic");
        ret_q.push_back('{OWN_MON, {16{8'hA5}}});
        tick(); settle(); expect_quiet("basic wait1");
        tick(); settle(); expect_quiet("basic wait2");
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = {16{8'hA5}}; settle();
        expect_ret("basic");
        tick(); bus.mem_read_valid = 0; bus.mem_rdata = 0; settle(); expect_quiet("basic idle");

        // CPU read timeout, then a late valid that must be dropped
        tick(); bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 32'h300; iss_q.push_back(32'h300); settle();
        chk("to ack", bus.cpu_ack, 1);
        tick(); bus.cpu_req = 0; settle();
        expect_issue("to");
        ret_q.push_back('{OWN_CPU, '0});
        repeat (3) begin tick(); settle(); expect_quiet("to wait"); end
        tick(); settle();
        chk("to rd_timeout", bus.rd_timeout, 1);
        expect_ret("to");
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = '1; settle(); expect_quiet("to late valid");
        tick(); bus.mem_read_valid = 0; bus.mem_rdata = 0; settle();

        // Data in the last allowed cycle wins over the timeout
        tick(); bus.cpu_req = 1; bus.cpu_adr = 32'h340; iss_q.push_back(32'h340); settle();
        chk("edge ack", bus.cpu_ack, 1);
        tick(); bus.cpu_req = 0; settle();
        expect_issue("edge");
        pat = {4{32'h1234_5678}};
        ret_q.push_back('{OWN_CPU, pat});
        repeat (3) begin tick(); settle(); expect_quiet("edge wait"); end
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = pat; settle();
        chk("edge rd_timeout", bus.rd_timeout, 0);
        expect_ret("edge");
        tick(); bus.mem_read_valid = 0; settle(); expect_quiet("edge idle");

        // Contention with last_grant = CPU: monitor first, CPU issues at M+2
        tick(); bus.mon_read_start = 1; bus.mon_radr = 32'h400;
        bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 32'h200; iss_q.push_back(32'h400); settle();
        chk("cont ack early", bus.cpu_ack, 0);
        tick(); bus.mon_read_start = 0; settle();
        expect_issue("cont mon");
        chk("cont ack in read", bus.cpu_ack, 0);
        pat = {8{16'hBEEF}};
        ret_q.push_back('{OWN_MON, pat});
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = pat; settle();
        expect_ret("cont mon");
        chk("cont ack at M", bus.cpu_ack, 0);
        tick(); bus.mem_read_valid = 0; iss_q.push_back(32'h200); settle();
        chk("cont ack at M+1", bus.cpu_ack, 1);
        chk("cont no issue M+1", bus.mem_read_start, 0);
        tick(); bus.cpu_req = 0; settle();
        expect_issue("cont cpu");
        pat = {4{32'hC0DE_0001}};
        ret_q.push_back('{OWN_CPU, pat});
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = pat; settle();
        expect_ret("cont cpu");
        tick(); bus.mem_read_valid = 0; settle();

        // Pending overwrite during a CPU read, then a start coincident with its grant
        tick(); bus.cpu_req = 1; bus.cpu_adr = 32'h240; iss_q.push_back(32'h240); settle();
        chk("pend cpu ack", bus.cpu_ack, 1);
        tick(); bus.cpu_req = 0; bus.mon_read_start = 1; bus.mon_radr = 32'h500; settle();
        expect_issue("pend cpu");
        pat = {4{32'h0000_4444}};
        ret_q.push_back('{OWN_CPU, pat});
        tick(); bus.mon_radr = 32'h510; settle(); expect_quiet("pend overwrite");
        tick(); bus.mon_read_start = 0; bus.mem_read_valid = 1; bus.mem_rdata = pat; settle();
        expect_ret("pend cpu");
        tick(); bus.mem_read_valid = 0; bus.mon_read_start = 1; bus.mon_radr = 32'h600;
        iss_q.push_back(32'h510); settle();
        expect_quiet("pend grant");
        tick(); bus.mon_read_start = 0; settle();
        expect_issue("pend old");
        pat = {4{32'h0000_5555}};
        ret_q.push_back('{OWN_MON, pat});
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = pat; settle();
        expect_ret("pend old");
        tick(); bus.mem_read_valid = 0; iss_q.push_back(32'h600); settle();
        chk("pend M+1", bus.mem_read_start, 0);
        tick(); settle();
        expect_issue("pend new");
        pat = {4{32'h0000_6666}};
        ret_q.push_back('{OWN_MON, pat});
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = pat; settle();
        expect_ret("pend new");
        tick(); bus.mem_read_valid = 0; settle(); expect_quiet("pend done1");
        tick(); settle(); expect_quiet("pend done2");

        // Trash burst: monitor owns the write port for 8 cycles
        for (int i = 0; i < 8; i++) begin
            tick();
            bus.cpu_req = 1; bus.cpu_we = 1; bus.cpu_adr = 32'h700;
            bus.cpu_wdata = {4{32'hCAFE_F00D}}; bus.cpu_mask = 16'h00F0;
            bus.mon_wen = 1; bus.mon_wadr = 32'h800 + 32'(i * 16);
            bus.mon_wdata = {4{32'(i)}}; bus.mon_mask = 16'(i);
            settle();
            chk("trash mem_wadr", bus.mem_wadr, 32'h800 + 32'(i * 16));
            chk("trash mem_wdata", bus.mem_wdata, {4{32'(i)}});
            chk("trash cpu_ack", bus.cpu_ack, 0);
        end
        tick(); bus.mon_wen = 0; settle();
        chk("trash 9th ack", bus.cpu_ack, 1);
        chk("trash 9th wen", bus.mem_wen, 1);
        chk("trash 9th wadr", bus.mem_wadr, 32'h700);
        chk("trash 9th wdata", bus.mem_wdata, {4{32'hCAFE_F00D}});
        chk("trash 9th mask", bus.mem_mask, 16'h00F0);
        tick(); bus.cpu_req = 0; bus.cpu_we = 0; settle();
        chk("trash idle wen", bus.mem_wen, 0);

        // CPU read while the monitor is active
        tick(); bus.mon_active = 1; bus.cpu_req = 1; bus.cpu_we = 0; bus.cpu_adr = 32'h900; settle();
`ifdef ARB_MON_HOLD_EN
        chk("hold ack blocked", bus.cpu_ack, 0);
        repeat (2) begin tick(); settle(); chk("hold ack blocked", bus.cpu_ack, 0); end
        tick(); bus.mon_active = 0; iss_q.push_back(32'h900); settle();
        chk("hold ack after", bus.cpu_ack, 1);
`else
        iss_q.push_back(32'h900);
        chk("hold ack free", bus.cpu_ack, 1);
`endif
        tick(); bus.cpu_req = 0; bus.mon_active = 0; settle();
        expect_issue("hold");
        pat = {4{32'h0000_9999}};
        ret_q.push_back('{OWN_CPU, pat});
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = pat; settle();
        expect_ret("hold");
        tick(); bus.mem_read_valid = 0; settle();

        // Reset in ARB_RD_MON abandons the read
        tick(); bus.mon_read_start = 1; bus.mon_radr = 32'hA00; settle();
        tick(); bus.mon_read_start = 0; settle();
        chk("rstmid issued", bus.mem_read_start, 1);
        #2; rst_n = 1'b0; bus.mon_wen = 1; bus.mon_wadr = 32'hB00; settle();
        chk("rstmid mem_read_start", bus.mem_read_start, 0);
        chk("rstmid mem_radr", bus.mem_radr, 0);
        chk("rstmid mem_wen", bus.mem_wen, 0);
        chk("rstmid mem_wadr", bus.mem_wadr, 0);
        tick(); bus.mon_wen = 0; rst_n = 1'b1; settle();
        tick(); bus.mem_read_valid = 1; bus.mem_rdata = '1; settle();
        expect_quiet("rstmid idle valid");
        tick(); bus.mem_read_valid = 0; settle(); expect_quiet("rstmid no pend");

        chk("final ret queue", ret_q.size(), 0);
        chk("final issue queue", iss_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
